mem_port_arbiter: RTL and testbench

Arbitrates between the core's instruction-fetch port and its load/store data port for one shared single-ported memory. Each transaction runs through a small FSM and a memory request/acknowledge handshake, then returns read data with a one-cycle done pulse to the winning requester. Load/store has priority over fetch, with an optional starvation guard. The block sits between the fetch stage, the load/store path driven by `memWrite`/`loadCtrl`/`storeCtrl`, and the external memory.

---
 rtl/mem_port_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-ported memory between the instruction-fetch port and the
// load/store data port. Each transaction runs IDLE -> BUSY_F/BUSY_D -> DONE
// and completes with a one-cycle done pulse to its owner. Data has priority
// over fetch.
// Optional feature: define MEM_ARB_STARVE_GUARD_EN to compile in a burst
// counter that forces a fetch grant after MAX_DATA_BURST consecutive data
// grants made while fetch was waiting.
module mem_port_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int MAX_DATA_BURST = 4
) (
  input  logic                clk,
  input  logic                resetN,
  // fetch port
  input  logic                fetchReq,
  input  logic [ADDR_W-1:0]   fetchAddr,
  output logic                fetchDone,
  output logic [DATA_W-1:0]   fetchRData,
  // load/store port
  input  logic                dataReq,
  input  logic [ADDR_W-1:0]   dataAddr,
  input  logic                dataWrite,
  input  logic [DATA_W-1:0]   dataWData,
  input  logic [DATA_W/8-1:0] dataByteEn,
  output logic                dataDone,
  output logic [DATA_W-1:0]   dataRData,
  // memory port
  output logic                memReq,
  output logic [ADDR_W-1:0]   memAddr,
  output logic                memWrite,
  output logic [DATA_W-1:0]   memWData,
  output logic [DATA_W/8-1:0] memByteEn,
  input  logic                memAck,
  input  logic [DATA_W-1:0]   memRData
);

  // Reject configurations the byte enables and the 4-bit burst counter
  // cannot represent.
  if (MAX_DATA_BURST < 1 || MAX_DATA_BURST > 15 || (DATA_W % 8) != 0) begin : g_bad_param
    $error("mem_port_arbiter: illegal MAX_DATA_BURST or DATA_W");
  end

  typedef enum logic [1:0] {
    IDLE,
    BUSY_F,
    BUSY_D,
    DONE
  } state_t;

  state_t state;
  logic   force_fetch;
  logic   data_grant;
  logic   fetch_grant;

`ifdef MEM_ARB_STARVE_GUARD_EN
  logic [3:0] burst_cnt;

  // Fetch has waited through a full burst of data grants: it wins this time.
  assign force_fetch = fetchReq && (burst_cnt == 4'(MAX_DATA_BURST));

  // Count data grants that overtook a waiting fetch; any fetch grant or any
  // idle cycle without a fetch request starts the count over.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      burst_cnt <= '0;
    end else if (state == IDLE) begin
      if (!fetchReq || fetch_grant) begin
        burst_cnt <= '0;
      end else if (data_grant) begin
        burst_cnt <= burst_cnt + 4'd1;
      end
    end
  end
`else
  assign force_fetch = 1'b0;
`endif

  // Grant decisions are only meaningful in IDLE; DONE never samples requests.
  assign data_grant  = (state == IDLE) && dataReq && !force_fetch;
  assign fetch_grant = (state == IDLE) && fetchReq && !data_grant;

  // Transaction FSM with registered memory-side and requester-side outputs.
  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values and the block models real flops.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state      <= IDLE;
      memReq     <= 1'b0;
      memAddr    <= '0;
      memWrite   <= 1'b0;
      memWData   <= '0;
      memByteEn  <= '0;
      fetchDone  <= 1'b0;
      fetchRData <= '0;
      dataDone   <= 1'b0;
      dataRData  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (data_grant) begin
            memAddr   <= dataAddr;
            memWrite  <= dataWrite;
            memWData  <= dataWData;
            memByteEn <= dataByteEn;
            memReq    <= 1'b1;
            state     <= BUSY_D;
          end else if (fetch_grant) begin
            memAddr   <= fetchAddr;
            memWrite  <= 1'b0;
            memByteEn <= '0;
            memReq    <= 1'b1;
            state     <= BUSY_F;
          end
        end
        BUSY_F: begin
          if (memAck) begin
            memReq     <= 1'b0;
            fetchRData <= memRData;
            fetchDone  <= 1'b1;
            state      <= DONE;
          end
        end
        BUSY_D: begin
          if (memAck) begin
            memReq   <= 1'b0;
            if (!memWrite) begin
              dataRData <= memRData;
            end
            dataDone <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          fetchDone <= 1'b0;
          dataDone  <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Drives both requesters and plays the memory with random acknowledge delays.
// A transaction-level reference model decides the winner of every IDLE sample
// from the priority rules and predicts memory-side fields, done pulses and
// read data. Honors MEM_ARB_STARVE_GUARD_EN the same way the design does.
module tb_mem_port_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int BW   = DW / 8;
  localparam int MAXB = 4;

  logic          clk = 1'b0;
  logic          resetN;
  logic          fetchReq;
  logic [AW-1:0] fetchAddr;
  logic          fetchDone;
  logic [DW-1:0] fetchRData;
  logic          dataReq;
  logic [AW-1:0] dataAddr;
  logic          dataWrite;
  logic [DW-1:0] dataWData;
  logic [BW-1:0] dataByteEn;
  logic          dataDone;
  logic [DW-1:0] dataRData;
  logic          memReq;
  logic [AW-1:0] memAddr;
  logic          memWrite;
  logic [DW-1:0] memWData;
  logic [BW-1:0] memByteEn;
  logic          memAck;
  logic [DW-1:0] memRData;

  mem_port_arbiter #(
    .ADDR_W        (AW),
    .DATA_W        (DW),
    .MAX_DATA_BURST(MAXB)
  ) dut (
    .clk       (clk),
    .resetN    (resetN),
    .fetchReq  (fetchReq),
    .fetchAddr (fetchAddr),
    .fetchDone (fetchDone),
    .fetchRData(fetchRData),
    .dataReq   (dataReq),
    .dataAddr  (dataAddr),
    .dataWrite (dataWrite),
    .dataWData (dataWData),
    .dataByteEn(dataByteEn),
    .dataDone  (dataDone),
    .dataRData (dataRData),
    .memReq    (memReq),
    .memAddr   (memAddr),
    .memWrite  (memWrite),
    .memWData  (memWData),
    .memByteEn (memByteEn),
    .memAck    (memAck),
    .memRData  (memRData)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // requester intent
  bit            f_pend;
  logic [AW-1:0] f_addr;
  bit            d_pend;
  logic          d_write;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [BW-1:0] d_be;

  // reference model state
  int            burst_model;
  logic [DW-1:0] exp_frd;
  logic [DW-1:0] exp_drd;
  int            dut_fetch_dones;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic drive_reqs();
    fetchReq   = f_pend;
    fetchAddr  = f_addr;
    dataReq    = d_pend;
    dataAddr   = d_addr;
    dataWrite  = d_write;
    dataWData  = d_wdata;
    dataByteEn = d_be;
  endtask

  task automatic new_fetch(input logic [AW-1:0] a);
    f_pend = 1'b1;
    f_addr = a;
  endtask

  task automatic new_data(input logic w, input logic [AW-1:0] a,
                          input logic [DW-1:0] wd, input logic [BW-1:0] be);
    d_pend  = 1'b1;
    d_write = w;
    d_addr  = a;
    d_wdata = wd;
    d_be    = be;
  endtask

  // Entered just after the negedge of an IDLE sample cycle; returns just after
  // the negedge of the next IDLE sample cycle.
  task automatic sample_cycle(input int ack_delay, input logic [DW-1:0] rd, input bit stray_ack);
    int            w;
    bit            force_f;
    logic [AW-1:0] e_addr;
    logic          e_write;
    logic [DW-1:0] e_wdata;
    logic [BW-1:0] e_be;

    check("idle_fetchDone", fetchDone, 0);
    check("idle_dataDone", dataDone, 0);
    check("idle_memReq", memReq, 0);
    drive_reqs();
    memAck   = stray_ack;
    memRData = $urandom;

    // reference arbitration
    force_f = 1'b0;
`ifdef MEM_ARB_STARVE_GUARD_EN
    force_f = f_pend && (burst_model == MAXB);
`endif
    if (d_pend && !force_f) w = 2;
    else if (f_pend)        w = 1;
    else                    w = 0;
    if (!f_pend || w == 1) burst_model = 0;
    else if (w == 2)       burst_model++;

    @(negedge clk);
    if (w == 0) begin
      memAck = 1'b0;
      check("noreq_memReq", memReq, 0);
      check("noreq_fetchDone", fetchDone, 0);
      check("noreq_dataDone", dataDone, 0);
      check("noreq_fetchRData", fetchRData, exp_frd);
      check("noreq_dataRData", dataRData, exp_drd);
      return;
    end

    if (w == 2) begin
      e_addr = d_addr; e_write = d_write; e_wdata = d_wdata; e_be = d_be;
    end else begin
      e_addr = f_addr; e_write = 1'b0; e_wdata = '0; e_be = '0;
    end

    memAck = 1'b0;
    for (int i = 0; i <= ack_delay; i++) begin
      check("busy_memReq", memReq, 1);
      check("busy_memAddr", memAddr, e_addr);
      check("busy_memWrite", memWrite, e_write);
      check("busy_memByteEn", memByteEn, e_be);
      if (w == 2) check("busy_memWData", memWData, e_wdata);
      check("busy_fetchDone", fetchDone, 0);
      check("busy_dataDone", dataDone, 0);
      if (i == ack_delay) begin
        memAck   = 1'b1;
        memRData = rd;
      end
      @(negedge clk);
    end
    memAck = 1'b0;

    if (w == 1)                exp_frd = rd;
    if (w == 2 && !d_write)    exp_drd = rd;
    check("done_fetchDone", fetchDone, (w == 1));
    check("done_dataDone", dataDone, (w == 2));
    check("done_memReq", memReq, 0);
    check("done_fetchRData", fetchRData, exp_frd);
    check("done_dataRData", dataRData, exp_drd);
    if (fetchDone === 1'b1) dut_fetch_dones++;

    if (w == 1) f_pend = 1'b0;
    else        d_pend = 1'b0;
    drive_reqs();
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int expect_fetches;

    f_pend = 0; f_addr = '0;
    d_pend = 0; d_write = 0; d_addr = '0; d_wdata = '0; d_be = '0;
    burst_model = 0; exp_frd = '0; exp_drd = '0; dut_fetch_dones = 0;
    resetN = 1'b0;
    drive_reqs();
    memAck = 1'b0; memRData = '0;

    // reset values
    repeat (2) @(negedge clk);
    check("rst_memReq", memReq, 0);
    check("rst_memWrite", memWrite, 0);
    check("rst_memAddr", memAddr, 0);
    check("rst_memWData", memWData, 0);
    check("rst_memByteEn", memByteEn, 0);
    check("rst_fetchDone", fetchDone, 0);
    check("rst_dataDone", dataDone, 0);
    check("rst_fetchRData", fetchRData, 0);
    check("rst_dataRData", dataRData, 0);
    resetN = 1'b1;

    // fetch only, ack in the first memReq cycle
    new_fetch(32'h100);
    sample_cycle(0, 32'hDEADBEEF, 1'b0);

    // store with two cycles of ack delay
    new_data(1'b1, 32'h40, 32'h12345678, 4'h3);
    sample_cycle(2, 32'hCAFEF00D, 1'b0);

    // stray acknowledges while idle with no requests
    repeat (3) sample_cycle(0, 32'h0, 1'b1);

    // simultaneous requests: data first, then fetch
    new_fetch(32'h200);
    new_data(1'b0, 32'h80, 32'h0, 4'h0);
    sample_cycle(1, 32'hA5A5_0001, 1'b0);
    sample_cycle(0, 32'h5A5A_0002, 1'b0);

    // both ports saturated for 20 transactions
    dut_fetch_dones = 0;
    for (int n = 0; n < 20; n++) begin
      if (!f_pend) new_fetch($urandom);
      if (!d_pend) new_data($urandom_range(0, 1), $urandom, $urandom, BW'($urandom));
      sample_cycle($urandom_range(0, 2), $urandom, 1'b0);
    end
`ifdef MEM_ARB_STARVE_GUARD_EN
    expect_fetches = 20 / (MAXB + 1);
`else
    expect_fetches = 0;
`endif
    check("saturated_fetch_grants", dut_fetch_dones, expect_fetches);

    // let the leftover request drain so the reset test starts clean
    while (f_pend || d_pend) sample_cycle(0, $urandom, 1'b0);

    // reset in the middle of a load
    new_data(1'b0, 32'h44, 32'h0, 4'h0);
    drive_reqs();
    @(negedge clk);
    check("pre_rst_memReq", memReq, 1);
    @(negedge clk);
    resetN = 1'b0;
    #1;
    check("midrst_memReq", memReq, 0);
    check("midrst_dataDone", dataDone, 0);
    check("midrst_memAddr", memAddr, 0);
    check("midrst_dataRData", dataRData, 0);
    check("midrst_fetchRData", fetchRData, 0);
    d_pend = 1'b0;
    drive_reqs();
    memAck = 1'b1;
    @(negedge clk);
    check("inrst_dataDone", dataDone, 0);
    memAck = 1'b0;
    resetN = 1'b1;
    exp_frd = '0; exp_drd = '0; burst_model = 0;
    sample_cycle(0, 32'h0, 1'b0);
    new_fetch(32'h300);
    sample_cycle(1, 32'h1234_ABCD, 1'b0);

    // random traffic
    for (int n = 0; n < 150; n++) begin
      if (!f_pend && $urandom_range(0, 1)) new_fetch($urandom);
      if (!d_pend && $urandom_range(0, 1))
        new_data($urandom_range(0, 1), $urandom, $urandom, BW'($urandom));
      sample_cycle($urandom_range(0, 3), $urandom, $urandom_range(0, 1) == 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
